// File: rtl/eth_sync_feeder.sv
// eth_sync_feeder: FIFO that paces words to a clock-domain synchronizer as spaced single-cycle strobes
module eth_sync_feeder #(
  parameter int         WIDTH      = 16,
  parameter int         DEPTH_LOG2 = 2,
  parameter logic [7:0] GAP        = 8'd16
) (
  input  logic                  clka,
  input  logic                  res,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  ovf,
  input  logic                  ovf_clr,
  output logic                  ena_buf,
  output logic [WIDTH-1:0]      buf_data,
  output logic                  busy
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wp, rp;
  logic [7:0] cnt;
  logic pop, accept, ovf_set;
  assign full    = level == (DEPTH_LOG2 + 1)'(DEPTH);
  assign empty   = level == '0;
  assign busy    = cnt != 8'd0;
  assign pop     = !empty && !busy && !ena_buf;
  assign accept  = wr_en && (!full || pop);
  assign ovf_set = wr_en && full && !pop;
  // storage array; no reset needed since level gates every read
  always_ff @(posedge clka) begin
    if (accept) mem[wp] <= wr_data;
  end
  // pointers, occupancy, overflow flag, holdoff counter and strobe output
  always_ff @(posedge clka or negedge res) begin
    if (!res) begin
      wp       <= '0;
      rp       <= '0;
      level    <= '0;
      ovf      <= 1'b0;
      cnt      <= 8'd0;
      ena_buf  <= 1'b0;
      buf_data <= '0;
    end else begin
      wp       <= accept ? wp + 1'b1 : wp;
      rp       <= pop ? rp + 1'b1 : rp;
      level    <= (accept && !pop) ? level + 1'b1 : (!accept && pop) ? level - 1'b1 : level;
      ovf      <= ovf_set ? 1'b1 : ovf_clr ? 1'b0 : ovf;
      cnt      <= pop ? GAP : busy ? cnt - 8'd1 : cnt;
      ena_buf  <= pop;
      buf_data <= pop ? mem[rp] : buf_data;
    end
  end
endmodule

// File: tb/tb_eth_sync_feeder.sv
// tb_eth_sync_feeder: randomized scoreboard bench with a queue/time-based reference model
module tb_eth_sync_feeder;
  localparam int GAP = 16;
  localparam int DEPTH = 4;
  logic clka = 1'b0, res = 1'b0, wr_en = 1'b0, ovf_clr = 1'b0;
  logic [15:0] wr_data = '0;
  logic full, empty, ovf, ena_buf, busy;
  logic [2:0] level;
  logic [15:0] buf_data;
  int n_chk = 0, n_fail = 0;
  eth_sync_feeder #(.WIDTH(16), .DEPTH_LOG2(2), .GAP(8'(GAP))) dut (
    .clka(clka), .res(res), .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty),
    .level(level), .ovf(ovf), .ovf_clr(ovf_clr), .ena_buf(ena_buf), .buf_data(buf_data), .busy(busy)
  );
  always #5 clka = ~clka;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // reference model: a word queue plus the earliest edge number at which the next strobe may go out
  logic [15:0] q[$], sb[$];
  int cyc = 0, next_ok = 0;
  bit m_ena = 0, m_ovf = 0;
  logic [15:0] m_buf = '0;
  always @(posedge clka or negedge res) begin
    bit issue, acc;
    if (!res) begin
      q.delete(); sb.delete();
      m_ena = 0; m_ovf = 0; m_buf = '0; next_ok = 0;
    end else begin
      cyc++;
      issue = q.size() > 0 && cyc >= next_ok;
      acc = wr_en && (q.size() < DEPTH || issue);
      m_ena = issue;
      if (issue) begin
        m_buf = q.pop_front();
        next_ok = cyc + GAP + 1;
      end
      if (acc) begin
        q.push_back(wr_data);
        sb.push_back(wr_data);
      end
      m_ovf = (wr_en && !acc) ? 1'b1 : ovf_clr ? 1'b0 : m_ovf;
    end
  end
  // monitor: compare flags against the model and pop the scoreboard on each strobe
  always @(negedge clka) begin
    if (res) begin
      chk("ena_buf", 32'(ena_buf), 32'(m_ena));
      chk("level", 32'(level), 32'(q.size()));
      chk("full", 32'(full), 32'(q.size() == DEPTH));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("busy", 32'(busy), 32'(cyc < next_ok - 1));
      chk("buf_hold", 32'(buf_data), 32'(m_buf));
      if (ena_buf) begin
        if (sb.size() == 0) chk("sb_nonempty", 32'(0), 32'(1));
        else chk("order", 32'(buf_data), 32'(sb.pop_front()));
      end
    end
  end
  task automatic step(input bit w, input logic [15:0] d, input bit c);
    wr_en = w; wr_data = d; ovf_clr = c;
    @(negedge clka);
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_ena"}, 32'(ena_buf), 0);
    chk({nm, "_level"}, 32'(level), 0);
    chk({nm, "_empty"}, 32'(empty), 1);
    chk({nm, "_full"}, 32'(full), 0);
    chk({nm, "_ovf"}, 32'(ovf), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_buf"}, 32'(buf_data), 0);
  endtask
  initial begin
    @(negedge clka);
    repeat (2) @(negedge clka);
    chk_reset("rst");
    res = 1'b1;
    step(1, 16'hA5A5, 0);
    repeat (20) step(0, 0, 0);
    for (int i = 1; i <= 4; i++) step(1, 16'(i), 0);
    repeat (70) step(0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 16'h0011 + 16'(i), 0);
    step(1, 16'hDEAD, 0);
    step(0, 0, 1);
    step(1, 16'hBEEF, 1);
    for (int i = 0; i < 20; i++) step(1, 16'h0100 + 16'(i), 0);
    repeat (100) step(0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 16'h0200 + 16'(i), 0);
    repeat (3) step(0, 0, 0);
    #2 res = 1'b0;
    #1 chk_reset("async_rst");
    @(negedge clka);
    res = 1'b1;
    repeat (40) step(0, 0, 0);
    for (int p = 0; p < 3; p++) begin
      int th = (p == 0) ? 2 : (p == 1) ? 8 : 1;
      repeat (500) step($urandom_range(0, th - 1) == 0 ^ (p == 2), 16'($urandom), $urandom_range(0, 15) == 0);
    end
    repeat (120) step(0, 0, 0);
    chk("drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
